// File: rtl/scsi_cd_target.sv
// SCSI CD-ROM target: selection, command-in, data-in, status and message-in phases with REQ/ACK handshakes.
// Outputs are registered state decodes; every transition advances only on CE; bus reset returns to IDLE.
module scsi_cd_target #(
    parameter int TARGET_ID = 0,
    parameter int DESKEW    = 2
) (
    input  logic       CLK,
    input  logic       RES,
    input  logic       CE,
    input  logic [7:0] SCSI_DI,
    input  logic       SCSI_SELn,
    input  logic       SCSI_ATNn,
    input  logic       SCSI_ACKn,
    input  logic       SCSI_RSTn,
    output logic [7:0] SCSI_DO,
    output logic       SCSI_DOE,
    output logic       SCSI_BSYn,
    output logic       SCSI_REQn,
    output logic       SCSI_MSGn,
    output logic       SCSI_CDn,
    output logic       SCSI_IOn,
    output logic [7:0] CMD_BYTE,
    output logic       CMD_STB,
    output logic       CMD_END,
    input  logic [7:0] DIN_DATA,
    input  logic       DIN_VALID,
    input  logic       DIN_LAST,
    output logic       DIN_READY,
    input  logic       DIN_GO,
    input  logic       STAT_GO,
    input  logic [7:0] STAT_BYTE,
    output logic       BUSY
);

    typedef enum logic [2:0] {
        IDLE, SELECTED, COMMAND, WAIT_CTL, DATA_IN, STATUS, MSG_IN
    } state_t;

    typedef enum logic [1:0] {
        HS_IDLE, HS_SKEW, HS_REQ, HS_ACK
    } hs_t;

    localparam logic [2:0] ID        = 3'(TARGET_ID);
    localparam logic [7:0] SKEW_LAST = (DESKEW > 1) ? 8'(DESKEW - 1) : 8'd0;

    // Last byte index of the command descriptor block, from the opcode group code.
    function automatic logic [3:0] cmd_last(input logic [2:0] grp);
        case (grp)
            3'd0:       return 4'd5;
            3'd1, 3'd2: return 4'd9;
            3'd5:       return 4'd11;
            default:    return 4'd5;
        endcase
    endfunction

    state_t     state, n_state;
    hs_t        hs, n_hs;
    logic [7:0] skew_cnt, n_cnt;
    logic       req, n_req;
    logic [7:0] dout, n_dout;
    logic [7:0] cmd_byte, n_cmd_byte;
    logic       stb, n_stb;
    logic       endp, n_end;
    logic [3:0] byte_idx, n_idx;
    logic [3:0] last_idx, n_last_idx;
    logic       last_flag, n_last;

    logic       launch;
    logic [7:0] launch_byte;
    logic       byte_done;
    logic [3:0] cur_last;
    logic       atn_unused;

    assign atn_unused = SCSI_ATNn;
    assign cur_last   = (byte_idx == 4'd0) ? cmd_last(SCSI_DI[7:5]) : last_idx;

    always_ff @(posedge CLK or posedge RES) begin
        if (RES) begin
            state     <= IDLE;
            hs        <= HS_IDLE;
            skew_cnt  <= 8'd0;
            req       <= 1'b0;
            dout      <= 8'h00;
            cmd_byte  <= 8'h00;
            stb       <= 1'b0;
            endp      <= 1'b0;
            byte_idx  <= 4'd0;
            last_idx  <= 4'd5;
            last_flag <= 1'b0;
        end else if (CE) begin
            state     <= n_state;
            hs        <= n_hs;
            skew_cnt  <= n_cnt;
            req       <= n_req;
            dout      <= n_dout;
            cmd_byte  <= n_cmd_byte;
            stb       <= n_stb;
            endp      <= n_end;
            byte_idx  <= n_idx;
            last_idx  <= n_last_idx;
            last_flag <= n_last;
        end
    end

    always_comb begin
        n_state     = state;
        n_hs        = hs;
        n_cnt       = skew_cnt;
        n_req       = req;
        n_dout      = dout;
        n_cmd_byte  = cmd_byte;
        n_stb       = 1'b0;
        n_end       = 1'b0;
        n_idx       = byte_idx;
        n_last_idx  = last_idx;
        n_last      = last_flag;
        launch      = 1'b0;
        launch_byte = 8'h00;
        byte_done   = 1'b0;

        if (!SCSI_RSTn) begin
            n_state = IDLE;
            n_hs    = HS_IDLE;
            n_req   = 1'b0;
            n_dout  = 8'h00;
            n_cnt   = 8'd0;
        end else begin
            case (state)
                IDLE: begin
                    if (!SCSI_SELn && SCSI_DI[ID])
                        n_state = SELECTED;
                end
                SELECTED: begin
                    if (SCSI_SELn) begin
                        n_state = COMMAND;
                        n_hs    = HS_REQ;
                        n_req   = 1'b1;
                        n_idx   = 4'd0;
                    end
                end
                COMMAND: begin
                    case (hs)
                        HS_REQ: begin
                            if (!SCSI_ACKn) begin
                                n_req      = 1'b0;
                                n_hs       = HS_ACK;
                                n_cmd_byte = SCSI_DI;
                                n_stb      = 1'b1;
                                n_last_idx = cur_last;
                                n_end      = (byte_idx == cur_last);
                            end
                        end
                        HS_ACK: begin
                            if (SCSI_ACKn) begin
                                if (byte_idx == last_idx) begin
                                    n_state = WAIT_CTL;
                                    n_hs    = HS_IDLE;
                                end else begin
                                    n_req = 1'b1;
                                    n_hs  = HS_REQ;
                                    n_idx = byte_idx + 4'd1;
                                end
                            end
                        end
                        default: ;
                    endcase
                end
                WAIT_CTL: begin
                    if (DIN_GO) begin
                        n_state = DATA_IN;
                        n_hs    = HS_IDLE;
                    end else if (STAT_GO) begin
                        n_state     = STATUS;
                        launch      = 1'b1;
                        launch_byte = STAT_BYTE;
                    end
                end
                DATA_IN, STATUS, MSG_IN: begin
                    case (hs)
                        HS_IDLE: begin
                            // Only the data-in phase waits here for the controller to supply a byte.
                            if (state == DATA_IN && DIN_VALID) begin
                                launch      = 1'b1;
                                launch_byte = DIN_DATA;
                                n_last      = DIN_LAST;
                            end
                        end
                        HS_SKEW: begin
                            if (skew_cnt >= SKEW_LAST) begin
                                n_req = 1'b1;
                                n_hs  = HS_REQ;
                            end else begin
                                n_cnt = skew_cnt + 8'd1;
                            end
                        end
                        HS_REQ: begin
                            if (!SCSI_ACKn) begin
                                n_req = 1'b0;
                                n_hs  = HS_ACK;
                            end
                        end
                        HS_ACK: begin
                            if (SCSI_ACKn)
                                byte_done = 1'b1;
                        end
                        default: ;
                    endcase

                    if (byte_done) begin
                        n_hs = HS_IDLE;
                        case (state)
                            DATA_IN: begin
                                if (last_flag)
                                    n_state = WAIT_CTL;
                            end
                            STATUS: begin
                                n_state     = MSG_IN;
                                launch      = 1'b1;
                                launch_byte = 8'h00;
                            end
                            default: n_state = IDLE;
                        endcase
                    end
                end
                default: n_state = IDLE;
            endcase

            if (launch) begin
                n_dout = launch_byte;
                n_cnt  = 8'd0;
                if (DESKEW == 0) begin
                    n_req = 1'b1;
                    n_hs  = HS_REQ;
                end else begin
                    n_hs = HS_SKEW;
                end
            end
        end
    end

    assign BUSY      = (state != IDLE);
    assign SCSI_BSYn = ~BUSY;
    assign SCSI_REQn = ~req;
    assign SCSI_MSGn = ~(state == MSG_IN);
    assign SCSI_CDn  = ~(state == COMMAND || state == STATUS || state == MSG_IN);
    assign SCSI_IOn  = ~(state == DATA_IN || state == STATUS || state == MSG_IN);
    assign SCSI_DOE  = ~SCSI_IOn;
    assign SCSI_DO   = SCSI_DOE ? dout : 8'h00;
    assign CMD_BYTE  = cmd_byte;
    assign CMD_STB   = stb & CE;
    assign CMD_END   = endp & CE;
    assign DIN_READY = (state == DATA_IN) && (hs == HS_IDLE) && SCSI_RSTn;

endmodule

// File: doc/scsi_cd_target.md
SCSI_CD_TARGET -- requirements
Module: scsi_cd_target

Interface
REQ-001 Parameter TARGET_ID, default 0: SCSI ID bit (0-7) this target answers on during selection.
REQ-002 Parameter DESKEW, default 2: CE cycles SCSI_DO is held stable before REQ assertion.
REQ-003 CLK  in  1  system clock; all logic advances only on CLK edges with CE=1.
REQ-004 RES  in  1  reset; asynchronous, active-high.
REQ-005 CE  in  1  clock enable.
REQ-006 SCSI_DI  in  8  initiator data bus, true polarity.
REQ-007 SCSI_SELn, SCSI_ATNn, SCSI_ACKn, SCSI_RSTn  in  1 each  initiator control lines, active-low.
REQ-008 SCSI_DO  out  8  target data bus; SCSI_DOE  out  1  target drives data.
REQ-009 SCSI_BSYn, SCSI_REQn, SCSI_MSGn, SCSI_CDn, SCSI_IOn  out  1 each  target control lines, active-low.
REQ-010 CMD_BYTE  out  8, CMD_STB  out  1: one-CE-cycle strobe per received command byte.
REQ-011 CMD_END  out  1: one-CE-cycle pulse with the final command byte's strobe.
REQ-012 DIN_DATA  in  8, DIN_VALID  in  1, DIN_LAST  in  1, DIN_READY  out  1: data-in byte stream from the drive controller.
REQ-013 DIN_GO  in  1, STAT_GO  in  1, STAT_BYTE  in  8: controller phase requests, sampled only in WAIT_CTL.
REQ-014 BUSY  out  1: high from selection acceptance until bus free.

Function
REQ-015 States: IDLE, SELECTED, COMMAND, WAIT_CTL, DATA_IN, STATUS, MSG_IN.
REQ-016 IDLE -> SELECTED when SCSI_SELn=0 and SCSI_DI[TARGET_ID]=1 in the same CE cycle; SCSI_BSYn goes 0 the next cycle.
REQ-017 SELECTED -> COMMAND once SCSI_SELn=1 is sampled.
REQ-018 Phase lines: COMMAND CDn=0; DATA_IN IOn=0; STATUS CDn=0, IOn=0; MSG_IN MSGn=0, CDn=0, IOn=0; all others 1.
REQ-019 SCSI_DOE = ~SCSI_IOn; SCSI_DO = 0 whenever SCSI_DOE=0.
REQ-020 Inbound byte (COMMAND): assert REQ; on ACK=0 latch SCSI_DI, pulse CMD_STB, deassert REQ; wait ACK=1 before the next REQ.
REQ-021 Outbound byte (DATA_IN/STATUS/MSG_IN): load SCSI_DO, wait DESKEW CE cycles, assert REQ; on ACK=0 deassert REQ; wait ACK=1; byte complete.
REQ-022 Command length from byte 0 bits [7:5]: 0 -> 6, 1 or 2 -> 10, 5 -> 12, other -> 6.
REQ-023 After the last command byte and ACK=1, state -> WAIT_CTL.
REQ-024 WAIT_CTL: DIN_GO -> DATA_IN; else STAT_GO -> STATUS with STAT_BYTE latched; DIN_GO wins if both asserted.
REQ-025 DATA_IN: DIN_READY=1 only while no byte is held; DIN_VALID & DIN_READY loads the byte; a DIN_LAST byte returns to WAIT_CTL once its handshake completes.
REQ-026 DIN_VALID low in DATA_IN stalls with REQ deasserted and holds the phase; no timeout.
REQ-027 STATUS sends the latched STAT_BYTE; MSG_IN sends 0x00 (COMMAND COMPLETE).
REQ-028 After MSG_IN: release all control lines and SCSI_BSYn=1 in the same cycle, BUSY=0, -> IDLE.
REQ-029 SCSI_ATNn is ignored; message-out is not supported.
REQ-030 SCSI_RSTn=0 in any state: next CE cycle -> IDLE, all outputs at reset values, held until SCSI_RSTn=1.
REQ-031 Selection while BUSY=1 is ignored.
REQ-032 CE=0 freezes all state and counters; CMD_STB and CMD_END assert only in CE=1 cycles.

Reset
REQ-033 RES=1 forces IDLE immediately regardless of CE.
REQ-034 During RES=1: SCSI_BSYn, SCSI_REQn, SCSI_MSGn, SCSI_CDn, SCSI_IOn = 1; SCSI_DO=0x00; SCSI_DOE=0; CMD_STB, CMD_END, DIN_READY, BUSY = 0.
REQ-035 RES=1 mid-handshake drops REQ and BSY without waiting for ACK; the partial byte is discarded.

Verification
REQ-036 SEL with DI=0x01 (TARGET_ID 0); initiator sends 6 bytes 0x08,0,0,0x10,0x01,0 -> 6 CMD_STB pulses with those values; CMD_END on the 6th; WAIT_CTL.
REQ-037 Opcode 0x28 -> exactly 10 bytes accepted; opcode 0xA8 -> 12 bytes.
REQ-038 DIN_GO, stream 0x11,0x22,0x33 with LAST on 0x33 and initiator ACK delayed 5 cycles -> 3 REQ pulses, IOn=0, DOE=1, each byte stable >=2 CE cycles before REQ.
REQ-039 STAT_GO with STAT_BYTE=0x02 -> status byte 0x02, then message 0x00 with MSGn=CDn=IOn=0, then BSYn=1, BUSY=0.
REQ-040 SCSI_RSTn=0 during the 3rd data-in byte with REQ low -> next cycle REQn=1, BSYn=1, IOn=1, IDLE; a new selection is accepted after SCSI_RSTn=1.
REQ-041 SEL with DI=0x02 while TARGET_ID=0 -> no BSY, state remains IDLE.
